// File: rtl/bp_pkg.sv
// bp_pkg: shared types, default sizes and helpers for the branch-prediction
// resolve queue.
//   bp_entry_t  one queued prediction {pc, taken} at the default PC width
//   ptr_w()     read/write pointer width: index bits plus one wrap bit
package bp_pkg;

   localparam int unsigned BP_DEPTH  = 8;
   localparam int unsigned BP_PC_W   = 32;
   localparam int unsigned BP_STAT_W = 32;

   typedef struct packed {
      logic [BP_PC_W-1:0] pc;
      logic               taken;
   } bp_entry_t;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: saturating event counter.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset, clears the count
//   inc_i    in   count one event this cycle
//   value_o  out  STAT_W current count, sticks at all-ones
module bp_sat_counter #(
   parameter int unsigned STAT_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              inc_i,
   output logic [STAT_W-1:0] value_o
);

   logic [STAT_W-1:0] value_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         value_q <= '0;
      end else if (inc_i && (value_q != '1)) begin
         value_q <= value_q + 1'b1;
      end
   end

   assign value_o = value_q;

endmodule

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: in-order queue of outstanding branch predictions.
// Fetch pushes {pc, taken}; execute resolves the head. Each accepted pop gives a
// registered one-cycle update strobe with the actual direction and PC for the
// history tracker, plus a one-cycle mispredict pulse for fetch redirect.
// A mispredicting pop or flush_i discards every younger (wrong-path) entry.
// Optional feature: define BP_STATS_EN to add saturating statistics counters
// (ports stat_resolved_o, stat_mispred_o; parameter STAT_W).
// Ports:
//   clk_i, rst_i                  clock; async active-high reset
//   en_i                          pipeline enable, 0 freezes all state
//   pred_valid_i/pc_i/taken_i     push side; pred_ready_o = !full_o
//   resolve_valid_i/taken_i       pop side (oldest branch)
//   flush_i                       discard all entries
//   update_en_o, last_taken_o,
//   update_pc_o, mispredict_o     registered pop results
//   count_o, full_o, empty_o      occupancy
module bp_resolve_queue
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH  = BP_DEPTH,
   parameter int unsigned PC_W   = BP_PC_W
`ifdef BP_STATS_EN
   ,
   parameter int unsigned STAT_W = BP_STAT_W
`endif
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       en_i,
   input  logic                       pred_valid_i,
   input  logic [PC_W-1:0]            pred_pc_i,
   input  logic                       pred_taken_i,
   output logic                       pred_ready_o,
   input  logic                       resolve_valid_i,
   input  logic                       resolve_taken_i,
   input  logic                       flush_i,
   output logic                       update_en_o,
   output logic                       last_taken_o,
   output logic [PC_W-1:0]            update_pc_o,
   output logic                       mispredict_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
`ifdef BP_STATS_EN
   output logic [STAT_W-1:0]          stat_resolved_o,
   output logic [STAT_W-1:0]          stat_mispred_o,
`endif
   output logic                       empty_o
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = ptr_w(DEPTH);

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            taken;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          head;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            full, empty;
   logic            push, pop, mispred, discard, write;

   logic            update_en_q, last_taken_q, mispredict_q;
   logic [PC_W-1:0] update_pc_q;

   assign head = mem[rd_ptr_q[IW-1:0]];

   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);

      pop     = en_i & resolve_valid_i & ~empty;
      mispred = pop & (head.taken != resolve_taken_i);
      // When full, a push is still taken if the head leaves in the same cycle;
      // the slot it writes is the one being popped.
      push    = en_i & pred_valid_i & (~full | pop);
      // Wrong-path or flushed: everything younger than the (possibly popped) head goes.
      discard = mispred | (en_i & flush_i);
      write   = push & ~discard;

      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = discard ? rd_ptr_d : (wr_ptr_q + PW'(push));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         update_en_q  <= 1'b0;
         last_taken_q <= 1'b0;
         mispredict_q <= 1'b0;
         update_pc_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         update_en_q  <= pop;
         mispredict_q <= mispred;
         if (pop) begin
            last_taken_q <= resolve_taken_i;
            update_pc_q  <= head.pc;
         end
      end
   end

   // Storage has no reset; only entries between the pointers are ever read out.
   always_ff @(posedge clk_i) begin
      if (write) begin
         mem[wr_ptr_q[IW-1:0]] <= '{pc: pred_pc_i, taken: pred_taken_i};
      end
   end

   assign pred_ready_o = ~full;
   assign full_o       = full;
   assign empty_o      = empty;
   assign count_o      = wr_ptr_q - rd_ptr_q;
   assign update_en_o  = update_en_q;
   assign last_taken_o = last_taken_q;
   assign update_pc_o  = update_pc_q;
   assign mispredict_o = mispredict_q;

`ifdef BP_STATS_EN
   bp_sat_counter #(
      .STAT_W (STAT_W)
   ) u_stat_resolved (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (pop),
      .value_o (stat_resolved_o)
   );

   bp_sat_counter #(
      .STAT_W (STAT_W)
   ) u_stat_mispred (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (mispred),
      .value_o (stat_mispred_o)
   );
`endif

endmodule
